// File: rtl/id_ex_stage_pkg.sv
// Shared decode constants for the ID/EX stage: opcode/funct fields, ALU codes, reset/write levels.
package id_ex_stage_pkg;

  localparam logic        RstEnable   = 1'b1;
  localparam logic        WriteEnable = 1'b1;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;

  typedef enum logic [7:0] {
    ALUOP_NOP = 8'h00,
    ALUOP_SRL = 8'h02,
    ALUOP_SRA = 8'h03,
    ALUOP_AND = 8'h24,
    ALUOP_OR  = 8'h25,
    ALUOP_XOR = 8'h26,
    ALUOP_NOR = 8'h27,
    ALUOP_SLL = 8'h7C
  } aluop_e;

  typedef enum logic [2:0] {
    ALUSEL_NOP   = 3'b000,
    ALUSEL_LOGIC = 3'b001,
    ALUSEL_SHIFT = 3'b010
  } alusel_e;

endpackage

// File: rtl/id_fwd_mux.sv
// One operand slot: immediate, hard zero, EX/MEM bypass or regfile data, plus hazard hit flags.
module id_fwd_mux #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int FWD_EN = 1
) (
  input  logic              re,
  input  logic [REG_AW-1:0] addr,
  input  logic [DATA_W-1:0] imm,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              ex_wreg,
  input  logic [REG_AW-1:0] ex_wd,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic              mem_wreg,
  input  logic [REG_AW-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] data,
  output logic              ex_hit,
  output logic              mem_hit
);

  always_comb begin
    ex_hit  = re && (addr != '0) && ex_wreg  && (ex_wd  == addr);
    mem_hit = re && (addr != '0) && mem_wreg && (mem_wd == addr);
  end

  always_comb begin
    data = rf_data;
    if (!re)                         data = imm;
    else if (addr == '0)             data = '0;
    else if (FWD_EN != 0 && ex_hit)  data = ex_wdata;
    else if (FWD_EN != 0 && mem_hit) data = mem_wdata;
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode stage with operand forwarding, hazard stall request and the ID/EX pipeline register.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [31:0]       inst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              reg1_read_o,
  output logic              reg2_read_o,
  output logic [REG_AW-1:0] reg1_addr_o,
  output logic [REG_AW-1:0] reg2_addr_o,
  input  logic [DATA_W-1:0] reg1_data_i,
  input  logic [DATA_W-1:0] reg2_data_i,
  input  logic              ex_wreg_i,
  input  logic [REG_AW-1:0] ex_wd_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  input  logic              ex_load_i,
  input  logic              mem_wreg_i,
  input  logic [REG_AW-1:0] mem_wd_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic              stallreq_o,
  output logic              ex_valid_o,
  output logic [7:0]        aluop_o,
  output logic [2:0]        alusel_o,
  output logic [DATA_W-1:0] reg1_o,
  output logic [DATA_W-1:0] reg2_o,
  output logic [REG_AW-1:0] wd_o,
  output logic              wreg_o,
  output logic [CNT_W-1:0]  inv_cnt_o
);

  logic [5:0]        op, funct;
  logic [4:0]        rs, rt, rd, sa;
  logic              dec_re1, dec_re2, dec_wreg, dec_inv;
  logic [4:0]        dec_wd;
  aluop_e            dec_aluop;
  alusel_e           dec_alusel;
  logic [31:0]       imm32;
  logic [DATA_W-1:0] imm, op1, op2;
  logic              ex_hit1, ex_hit2, mem_hit1, mem_hit2;
  logic              hold, bubble;

  assign op    = inst_i[31:26];
  assign rs    = inst_i[25:21];
  assign rt    = inst_i[20:16];
  assign rd    = inst_i[15:11];
  assign sa    = inst_i[10:6];
  assign funct = inst_i[5:0];
  assign imm   = DATA_W'(imm32);

  // The all-zero word is SLL $0,$0,0 by encoding, but is decoded as a NOP that writes nothing.
  always_comb begin
    dec_re1    = 1'b0;
    dec_re2    = 1'b0;
    dec_wd     = '0;
    dec_wreg   = ~WriteEnable;
    dec_aluop  = ALUOP_NOP;
    dec_alusel = ALUSEL_NOP;
    imm32      = ZeroWord;
    dec_inv    = 1'b1;
    if (inst_i == '0) begin
      dec_inv = 1'b0;
    end else begin
      case (op)
        OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
          dec_re1    = 1'b1;
          dec_wd     = rt;
          dec_wreg   = WriteEnable;
          dec_alusel = ALUSEL_LOGIC;
          dec_inv    = 1'b0;
          imm32      = {16'h0000, inst_i[15:0]};
          case (op)
            OP_ANDI: dec_aluop = ALUOP_AND;
            OP_XORI: dec_aluop = ALUOP_XOR;
            OP_LUI: begin
              dec_aluop = ALUOP_OR;
              imm32     = {inst_i[15:0], 16'h0000};
            end
            default: dec_aluop = ALUOP_OR;
          endcase
        end
        OP_SPECIAL: begin
          if (sa == '0 && (funct == FN_AND || funct == FN_OR ||
                           funct == FN_XOR || funct == FN_NOR)) begin
            dec_re1    = 1'b1;
            dec_re2    = 1'b1;
            dec_wd     = rd;
            dec_wreg   = WriteEnable;
            dec_alusel = ALUSEL_LOGIC;
            dec_inv    = 1'b0;
            case (funct)
              FN_AND:  dec_aluop = ALUOP_AND;
              FN_OR:   dec_aluop = ALUOP_OR;
              FN_XOR:  dec_aluop = ALUOP_XOR;
              default: dec_aluop = ALUOP_NOR;
            endcase
          end else if (rs == '0 && (funct == FN_SLL || funct == FN_SRL ||
                                    funct == FN_SRA)) begin
            dec_re2    = 1'b1;
            dec_wd     = rd;
            dec_wreg   = WriteEnable;
            dec_alusel = ALUSEL_SHIFT;
            dec_inv    = 1'b0;
            imm32      = {27'h0, sa};
            case (funct)
              FN_SRL:  dec_aluop = ALUOP_SRL;
              FN_SRA:  dec_aluop = ALUOP_SRA;
              default: dec_aluop = ALUOP_SLL;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    reg1_read_o = !rst && dec_re1;
    reg2_read_o = !rst && dec_re2;
    reg1_addr_o = reg1_read_o ? REG_AW'(rs) : '0;
    reg2_addr_o = reg2_read_o ? REG_AW'(rt) : '0;
  end

  id_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_fwd1 (
    .re(reg1_read_o), .addr(reg1_addr_o), .imm(imm), .rf_data(reg1_data_i),
    .ex_wreg(ex_wreg_i), .ex_wd(ex_wd_i), .ex_wdata(ex_wdata_i),
    .mem_wreg(mem_wreg_i), .mem_wd(mem_wd_i), .mem_wdata(mem_wdata_i),
    .data(op1), .ex_hit(ex_hit1), .mem_hit(mem_hit1)
  );

  id_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_fwd2 (
    .re(reg2_read_o), .addr(reg2_addr_o), .imm(imm), .rf_data(reg2_data_i),
    .ex_wreg(ex_wreg_i), .ex_wd(ex_wd_i), .ex_wdata(ex_wdata_i),
    .mem_wreg(mem_wreg_i), .mem_wd(mem_wd_i), .mem_wdata(mem_wdata_i),
    .data(op2), .ex_hit(ex_hit2), .mem_hit(mem_hit2)
  );

  always_comb begin
    stallreq_o = 1'b0;
    if (!rst && valid_i) begin
      if (FWD_EN != 0) stallreq_o = ex_load_i && (ex_hit1 || ex_hit2);
      else             stallreq_o = ex_hit1 || ex_hit2 || mem_hit1 || mem_hit2;
    end
  end

  // Flush outranks stall, so a held stage is still cleared when both arrive together.
  always_comb begin
    hold   = stall_i && !flush_i;
    bubble = flush_i || stallreq_o || !valid_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      ex_valid_o <= 1'b0;
      aluop_o    <= ALUOP_NOP;
      alusel_o   <= ALUSEL_NOP;
      reg1_o     <= '0;
      reg2_o     <= '0;
      wd_o       <= '0;
      wreg_o     <= 1'b0;
      inv_cnt_o  <= '0;
    end else if (!hold) begin
      if (bubble) begin
        ex_valid_o <= 1'b0;
        aluop_o    <= ALUOP_NOP;
        alusel_o   <= ALUSEL_NOP;
        reg1_o     <= '0;
        reg2_o     <= '0;
        wd_o       <= '0;
        wreg_o     <= 1'b0;
      end else begin
        ex_valid_o <= 1'b1;
        aluop_o    <= dec_aluop;
        alusel_o   <= dec_alusel;
        reg1_o     <= op1;
        reg2_o     <= op2;
        wd_o       <= REG_AW'(dec_wd);
        wreg_o     <= dec_wreg;
        if (dec_inv && inv_cnt_o != '1) inv_cnt_o <= inv_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboarded random bench for id_ex_stage, covering forwarding (FWD_EN=1) and stall-only (FWD_EN=0) builds.
module tb_id_ex_stage;

  typedef struct packed {
    logic        ev;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [4:0]  wd;
    logic        wreg;
    logic [1:0]  cnt;
  } out_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0, stall_i = 1'b0, flush_i = 1'b0;
  logic [31:0] inst_i = '0;
  logic [31:0] reg1_data_i = '0, reg2_data_i = '0;
  logic        ex_wreg_i = 1'b0, ex_load_i = 1'b0, mem_wreg_i = 1'b0;
  logic [4:0]  ex_wd_i = '0, mem_wd_i = '0;
  logic [31:0] ex_wdata_i = '0, mem_wdata_i = '0;

  logic        f_r1rd, f_r2rd, f_sreq, f_ev, f_wreg;
  logic [4:0]  f_r1a, f_r2a, f_wd;
  logic [7:0]  f_aluop;
  logic [2:0]  f_alusel;
  logic [31:0] f_r1, f_r2;
  logic [1:0]  f_cnt;
  logic        n_r1rd, n_r2rd, n_sreq, n_ev, n_wreg;
  logic [4:0]  n_r1a, n_r2a, n_wd;
  logic [7:0]  n_aluop;
  logic [2:0]  n_alusel;
  logic [31:0] n_r1, n_r2;
  logic [1:0]  n_cnt;

  id_ex_stage #(.DATA_W(32), .REG_AW(5), .FWD_EN(1), .CNT_W(2)) dut_f (
    .clk(clk), .rst(rst), .valid_i(valid_i), .inst_i(inst_i), .stall_i(stall_i), .flush_i(flush_i),
    .reg1_read_o(f_r1rd), .reg2_read_o(f_r2rd), .reg1_addr_o(f_r1a), .reg2_addr_o(f_r2a),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i), .ex_load_i(ex_load_i),
    .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
    .stallreq_o(f_sreq), .ex_valid_o(f_ev), .aluop_o(f_aluop), .alusel_o(f_alusel),
    .reg1_o(f_r1), .reg2_o(f_r2), .wd_o(f_wd), .wreg_o(f_wreg), .inv_cnt_o(f_cnt)
  );

  id_ex_stage #(.DATA_W(32), .REG_AW(5), .FWD_EN(0), .CNT_W(2)) dut_n (
    .clk(clk), .rst(rst), .valid_i(valid_i), .inst_i(inst_i), .stall_i(stall_i), .flush_i(flush_i),
    .reg1_read_o(n_r1rd), .reg2_read_o(n_r2rd), .reg1_addr_o(n_r1a), .reg2_addr_o(n_r2a),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i), .ex_load_i(ex_load_i),
    .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
    .stallreq_o(n_sreq), .ex_valid_o(n_ev), .aluop_o(n_aluop), .alusel_o(n_alusel),
    .reg1_o(n_r1), .reg2_o(n_r2), .wd_o(n_wd), .wreg_o(n_wreg), .inv_cnt_o(n_cnt)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  out_t        q_f[$], q_n[$];
  out_t        st_f, st_n;
  logic [31:0] rf[32];

  // Instruction semantics: which slots read, immediate, destination, ALU codes, validity.
  function automatic void decode(input logic [31:0] ins, output logic re1, output logic re2,
                                 output logic [31:0] imm, output logic [4:0] wd, output logic wr,
                                 output logic [7:0] aop, output logic [2:0] asel, output logic inv);
    logic [5:0] op, fn;
    op = ins[31:26]; fn = ins[5:0];
    re1 = 0; re2 = 0; imm = 0; wd = 0; wr = 0; aop = 0; asel = 0; inv = 1;
    if (ins == 0) inv = 0;
    else if (op == 6'h0c || op == 6'h0d || op == 6'h0e) begin
      re1 = 1; imm = {16'h0, ins[15:0]}; wd = ins[20:16]; wr = 1; asel = 3'd1; inv = 0;
      aop = (op == 6'h0c) ? 8'h24 : (op == 6'h0d) ? 8'h25 : 8'h26;
    end else if (op == 6'h0f) begin
      re1 = 1; imm = {ins[15:0], 16'h0}; wd = ins[20:16]; wr = 1; asel = 3'd1; aop = 8'h25; inv = 0;
    end else if (op == 0 && ins[10:6] == 0 && fn >= 6'h24 && fn <= 6'h27) begin
      re1 = 1; re2 = 1; wd = ins[15:11]; wr = 1; asel = 3'd1; aop = {2'b00, fn}; inv = 0;
    end else if (op == 0 && ins[25:21] == 0 && (fn == 6'h00 || fn == 6'h02 || fn == 6'h03)) begin
      re2 = 1; imm = {27'h0, ins[10:6]}; wd = ins[15:11]; wr = 1; asel = 3'd2; inv = 0;
      aop = (fn == 6'h00) ? 8'h7c : {2'b00, fn};
    end
  endfunction

  function automatic bit hit(input logic en, input logic [4:0] a, input logic w, input logic [4:0] d);
    return en && a != 0 && w && d == a;
  endfunction

  function automatic logic [31:0] operand(input logic en, input logic [4:0] a, input logic [31:0] imm,
                                          input logic [31:0] rfv, input bit fwd);
    if (!en) return imm;
    if (a == 0) return 0;
    if (fwd && hit(en, a, ex_wreg_i, ex_wd_i)) return ex_wdata_i;
    if (fwd && hit(en, a, mem_wreg_i, mem_wd_i)) return mem_wdata_i;
    return rfv;
  endfunction

  function automatic bit exp_sreq(input bit fwd);
    logic re1, re2, wr, inv; logic [31:0] imm; logic [4:0] wd; logic [7:0] aop; logic [2:0] asel;
    bit eh, mh;
    decode(inst_i, re1, re2, imm, wd, wr, aop, asel, inv);
    eh = hit(re1, inst_i[25:21], ex_wreg_i, ex_wd_i) || hit(re2, inst_i[20:16], ex_wreg_i, ex_wd_i);
    mh = hit(re1, inst_i[25:21], mem_wreg_i, mem_wd_i) || hit(re2, inst_i[20:16], mem_wreg_i, mem_wd_i);
    return valid_i && (fwd ? (eh && ex_load_i) : (eh || mh));
  endfunction

  function automatic out_t next_out(input out_t cur, input bit fwd);
    logic re1, re2, wr, inv; logic [31:0] imm; logic [4:0] wd; logic [7:0] aop; logic [2:0] asel;
    out_t n;
    decode(inst_i, re1, re2, imm, wd, wr, aop, asel, inv);
    n = '0;
    n.cnt = cur.cnt;
    if (flush_i) return n;
    if (stall_i) return cur;
    if (exp_sreq(fwd) || !valid_i) return n;
    n.ev = 1; n.aluop = aop; n.alusel = asel; n.wd = wd; n.wreg = wr;
    n.r1 = operand(re1, inst_i[25:21], imm, reg1_data_i, fwd);
    n.r2 = operand(re2, inst_i[20:16], imm, reg2_data_i, fwd);
    if (inv && cur.cnt != 2'd3) n.cnt = cur.cnt + 2'd1;
    return n;
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] ins, input logic st, input logic fl,
                      input logic ewr, input logic [4:0] ewd, input logic [31:0] ewdata, input logic eld,
                      input logic mwr, input logic [4:0] mwd, input logic [31:0] mwdata);
    logic re1, re2, wr, inv; logic [31:0] imm; logic [4:0] wd; logic [7:0] aop; logic [2:0] asel;
    @(negedge clk);
    valid_i = v; inst_i = ins; stall_i = st; flush_i = fl;
    ex_wreg_i = ewr; ex_wd_i = ewd; ex_wdata_i = ewdata; ex_load_i = eld;
    mem_wreg_i = mwr; mem_wd_i = mwd; mem_wdata_i = mwdata;
    reg1_data_i = rf[ins[25:21]]; reg2_data_i = rf[ins[20:16]];
    #1;
    decode(ins, re1, re2, imm, wd, wr, aop, asel, inv);
    check("fwd_stallreq", 128'(f_sreq), 128'(exp_sreq(1)));
    check("nofwd_stallreq", 128'(n_sreq), 128'(exp_sreq(0)));
    check("read_ports", 128'({f_r1rd, f_r1a, f_r2rd, f_r2a}),
          128'({re1, re1 ? ins[25:21] : 5'd0, re2, re2 ? ins[20:16] : 5'd0}));
    st_f = next_out(st_f, 1); q_f.push_back(st_f);
    st_n = next_out(st_n, 0); q_n.push_back(st_n);
  endtask

  task automatic rand_step();
    logic [31:0] ins;
    logic [5:0]  fns[7];
    fns = '{6'h24, 6'h25, 6'h26, 6'h27, 6'h00, 6'h02, 6'h03};
    case ($urandom_range(0, 7))
      0, 1:    ins = {6'h0c + 6'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
      2, 3:    ins = {6'h00, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'd0, fns[$urandom_range(0, 3)]};
      4:       ins = {6'h00, 5'd0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom), fns[$urandom_range(4, 6)]};
      5:       ins = {6'h00, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 1)), fns[$urandom_range(0, 6)]};
      6:       ins = '0;
      default: ins = $urandom;
    endcase
    step($urandom_range(0, 7) != 0, ins, $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
         1'($urandom), 5'($urandom_range(0, 3)), $urandom, $urandom_range(0, 3) == 0,
         1'($urandom), 5'($urandom_range(0, 3)), $urandom);
  endtask

  // Reset between edges with a hazard pending: bubble outputs, zero counter and quiet read/stall ports.
  task automatic mid_reset();
    @(negedge clk);
    valid_i = 1; inst_i = {6'h0d, 5'd1, 5'd2, 16'h1234}; stall_i = 1; flush_i = 0;
    ex_wreg_i = 1; ex_wd_i = 5'd1; ex_load_i = 1; mem_wreg_i = 1; mem_wd_i = 5'd1;
    rst = 1;
    #1;
    check("reset_outputs", 128'({f_ev, f_aluop, f_alusel, f_r1, f_r2, f_wd, f_wreg, f_cnt}), 128'(0));
    check("reset_nofwd_outputs", 128'({n_ev, n_aluop, n_alusel, n_r1, n_r2, n_wd, n_wreg, n_cnt}), 128'(0));
    check("reset_ports", 128'({f_r1rd, f_r2rd, f_r1a, f_r2a, f_sreq, n_sreq}), 128'(0));
    @(negedge clk);
    rst = 0; stall_i = 0;
    st_f = '0; st_n = '0;
  endtask

  initial begin : monitor
    out_t g, e;
    forever begin
      @(posedge clk);
      #1;
      if (q_f.size() > 0) begin
        e = q_f.pop_front();
        g = {f_ev, f_aluop, f_alusel, f_r1, f_r2, f_wd, f_wreg, f_cnt};
        check("fwd_out", 128'(g), 128'(e));
      end
      if (q_n.size() > 0) begin
        e = q_n.pop_front();
        g = {n_ev, n_aluop, n_alusel, n_r1, n_r2, n_wd, n_wreg, n_cnt};
        check("nofwd_out", 128'(g), 128'(e));
      end
    end
  end

  initial begin : stimulus
    logic [31:0] or_inst;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[1] = 32'h1234_0000;
    st_f = '0; st_n = '0;
    #2;
    check("initial_reset", 128'({f_ev, f_aluop, f_alusel, f_r1, f_r2, f_wd, f_wreg, f_cnt, f_sreq}), 128'(0));
    @(negedge clk);
    rst = 0;

    repeat (5) step(1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, {6'h0d, 5'd1, 5'd2, 16'h00FF}, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    or_inst = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h25};
    step(1, or_inst, 0, 0, 1, 5'd1, 32'hA, 0, 1, 5'd2, 32'hB);
    step(1, or_inst, 0, 0, 1, 5'd1, 32'hA, 1, 1, 5'd2, 32'hB);
    step(1, or_inst, 0, 0, 1, 5'd1, 32'hA, 0, 1, 5'd2, 32'hB);
    repeat (3) step(1, {6'h0e, 5'd3, 5'd4, 16'h5555}, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 32'hFFFF_FFFF, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, {6'h0f, 5'd0, 5'd7, 16'hBEEF}, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, {6'h00, 5'd0, 5'd1, 5'd9, 5'd31, 6'h03}, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, {6'h0d, 5'd2, 5'd2, 16'h0001}, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    mid_reset();

    for (int r = 0; r < 3; r++) begin
      repeat (250) rand_step();
      mid_reset();
    end

    for (int w = 0; w < 10 && (q_f.size() > 0 || q_n.size() > 0); w++) @(posedge clk);
    #2;
    check("scoreboard_drained", 128'(q_f.size() + q_n.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
